// File: rtl/mux2_to_1_32_pkg.sv
// Shared constants for the 2:1 select mux with registered output.
package mux2_to_1_32_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

endpackage : mux2_to_1_32_pkg

// File: rtl/mux2_to_1_32_if.sv
// Signal bundle between the mux and its user; clk and rst stay outside.
interface mux2_to_1_32_if
    import mux2_to_1_32_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic             sel;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic             en;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_q;
    logic             sel_q;

    modport master (
        output sel, in0, in1, en,
        input  out, out_q, sel_q
    );

    modport slave (
        input  sel, in0, in1, en,
        output out, out_q, sel_q
    );

endinterface : mux2_to_1_32_if

// File: rtl/mux2_to_1_32.sv
// 2:1 data mux with a combinational output and an enabled, synchronously
// reset registered copy of the result and of the select.
module mux2_to_1_32
    import mux2_to_1_32_pkg::*;
#(
    parameter int unsigned      WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    mux2_to_1_32_if.slave        bus
);

    logic [WIDTH-1:0] w_out;
    logic             w_sel_clean;
    logic [WIDTH-1:0] r_out_q;
    logic             r_sel_q;

    // NOTE: defaults are assigned first so every path is fully specified and
    // no latch is inferred; an X/Z select falls to the in0 branch.
    always_comb begin
        w_out       = bus.in0;
        w_sel_clean = 1'b0;
        if (bus.sel) begin
            w_out       = bus.in1;
            w_sel_clean = 1'b1;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values; rst is synchronous and overrides en.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_q <= RESET_VAL;
            r_sel_q <= 1'b0;
        end else if (bus.en) begin
            r_out_q <= w_out;
            r_sel_q <= w_sel_clean;
        end
    end

    assign bus.out   = w_out;
    assign bus.out_q = r_out_q;
    assign bus.sel_q = r_sel_q;

endmodule : mux2_to_1_32

// File: tb/tb_mux2_to_1_32.sv
// Directed and randomised checks of mux2_to_1_32 against hand values and a small model.
module tb_mux2_to_1_32;

    localparam int unsigned W      = 32;
    localparam logic [W-1:0] RST_V = '0;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic [W-1:0] m_q;
    logic         m_sel;

    mux2_to_1_32_if #(.WIDTH(W)) bus ();

    mux2_to_1_32 #(.WIDTH(W), .RESET_VAL(RST_V)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the reference model with pre-edge inputs, then step past the edge.
    task automatic tick();
        if (rst) begin
            m_q   = RST_V;
            m_sel = 1'b0;
        end else if (bus.en) begin
            m_q   = (bus.sel === 1'b1) ? bus.in1 : bus.in0;
            m_sel = (bus.sel === 1'b1);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] one_hot;
        logic [W-1:0] exp_v;

        m_q     = RST_V;
        m_sel   = 1'b0;
        rst     = 1'b1;
        bus.en  = 1'b0;
        bus.sel = 1'b0;
        bus.in0 = '0;
        bus.in1 = '0;
        tick();
        check("reset_out_q", bus.out_q, 64'h0);
        check("reset_sel_q", bus.sel_q, 64'h0);

        rst     = 1'b0;
        bus.in0 = 32'h0000_0004;
        bus.in1 = 32'h0000_ABCD;
        bus.sel = 1'b0;
        #1 check("comb_sel0", bus.out, 64'h4);
        bus.sel = 1'b1;
        #1 check("comb_sel1", bus.out, 64'hABCD);

        bus.en = 1'b1;
        tick();
        check("load_abcd", bus.out_q, 64'hABCD);

        // Reset wins over en; the combinational path is untouched.
        rst     = 1'b1;
        bus.in1 = 32'hFFFF_FFFF;
        #1 check("rst_comb_pre", bus.out, 64'hFFFF_FFFF);
        tick();
        check("rst_out_q", bus.out_q, 64'h0);
        check("rst_sel_q", bus.sel_q, 64'h0);
        check("rst_comb_post", bus.out, 64'hFFFF_FFFF);

        rst     = 1'b0;
        bus.in1 = 32'h1234_5678;
        tick();
        check("load_out_q", bus.out_q, 64'h1234_5678);
        check("load_sel_q", bus.sel_q, 64'h1);

        bus.en  = 1'b0;
        bus.in1 = '0;
        #1 check("hold_comb", bus.out, 64'h0);
        tick();
        check("hold_out_q", bus.out_q, 64'h1234_5678);
        bus.sel = 1'b0;
        tick();
        check("hold_sel_q", bus.sel_q, 64'h1);

        // Mid-cycle reset must not reach the register before the edge.
        rst = 1'b1;
        #2 check("rst_sync_wait", bus.out_q, 64'h1234_5678);
        tick();
        check("rst_sync_edge", bus.out_q, 64'h0);
        rst = 1'b0;

        // Simultaneous sel and data change.
        bus.in0 = 32'hDEAD_BEEF;
        bus.in1 = 32'hCAFE_F00D;
        bus.sel = 1'b1;
        #1 check("simul_change", bus.out, 64'hCAFE_F00D);

        for (int i = 0; i < 32; i++) begin
            one_hot = 32'h1 << i;
            bus.in0 = one_hot;
            bus.in1 = ~one_hot;
            bus.sel = i[0];
            exp_v   = i[0] ? ~one_hot : one_hot;
            #1 check($sformatf("walk_%0d", i), bus.out, exp_v);
        end

        bus.in0 = 32'hA5A5_A5A5;
        bus.in1 = 32'h5A5A_5A5A;
        bus.sel = 1'bx;
        exp_v   = (bus.sel === 1'b1) ? bus.in1 : bus.in0;
        #1 check("sel_x", bus.out, exp_v);

        bus.sel = 1'b0;
        rst     = 1'b1;
        tick();
        for (int n = 0; n < 1000; n++) begin
            rst     = ($urandom_range(15) == 0);
            bus.en  = 1'($urandom_range(1));
            bus.sel = 1'($urandom_range(1));
            bus.in0 = $urandom;
            bus.in1 = $urandom;
            exp_v   = bus.sel ? bus.in1 : bus.in0;
            #1 check("rnd_out", bus.out, exp_v);
            tick();
            check("rnd_out_q", bus.out_q, m_q);
            check("rnd_sel_q", bus.sel_q, m_sel);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mux2_to_1_32
